// File: rtl/blueberry_pkg.sv
// blueberry_pkg: opcode/state encodings and INST field positions shared by the ALU sequencer.
package blueberry_pkg;

    localparam int W        = 10;
    localparam int FN_W     = 4;
    localparam int NUM_REGS = 4;

    localparam int OP_MSB = 9;
    localparam int OP_LSB = 6;
    localparam int RX_MSB = 5;
    localparam int RX_LSB = 4;
    localparam int RY_MSB = 3;
    localparam int RY_LSB = 2;

    // Values match the ALU FN encoding; 12..15 are undefined.
    typedef enum logic [FN_W-1:0] {
        OP_LD  = 4'h0,
        OP_CP  = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_INV = 4'h4,
        OP_FLP = 4'h5,
        OP_AND = 4'h6,
        OP_OR  = 4'h7,
        OP_XOR = 4'h8,
        OP_LSL = 4'h9,
        OP_LSR = 4'hA,
        OP_ASR = 4'hB
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE,
        S_LOAD_A,
        S_LOAD_G,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        C_MOVE,
        C_UNARY,
        C_BINARY,
        C_ILLEGAL
    } opclass_t;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [1:0] idx);
        return {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: classifies an opcode as move, unary, binary or illegal.
module alu_seq_decode
    import blueberry_pkg::*;
(
    input  logic [FN_W-1:0] op,
    output opclass_t        cls
);

    always_comb
        cls = (op == OP_LD || op == OP_CP)  ? C_MOVE    :
              (op == OP_INV || op == OP_FLP) ? C_UNARY   :
              (op[3:2] == 2'b11)             ? C_ILLEGAL :
                                               C_BINARY;

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle FSM driving register-file bus enables and ALU strobes per instruction.
module alu_sequencer
    import blueberry_pkg::*;
(
    input  logic                CLKb,
    input  logic                Clr,
    input  logic                Exec,
    input  logic [W-1:0]        INST,
    output logic                Ready,
    output logic                Done,
    output logic                Illegal,
    output logic                Ain,
    output logic                Gin,
    output logic                Gout,
    output logic [FN_W-1:0]     FN,
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin,
    output logic                ENW
);

    state_t   state, nxt;
    logic [W-1:0] ir;
    opclass_t cls_inst, cls_ir;
    logic [NUM_REGS-1:0] rx_oh, ry_oh;
    logic is_ld, unused_ir;

    alu_seq_decode u_dec_inst (.op(INST[OP_MSB:OP_LSB]), .cls(cls_inst));
    alu_seq_decode u_dec_ir   (.op(ir[OP_MSB:OP_LSB]),   .cls(cls_ir));

    always_ff @(posedge CLKb)
        if (Clr) begin
            state <= S_IDLE;
            ir    <= '0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && Exec)
                ir <= INST;
        end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (Exec)
                          nxt = cls_inst == C_MOVE   ? S_MOVE   :
                                cls_inst == C_UNARY  ? S_LOAD_G :
                                cls_inst == C_BINARY ? S_LOAD_A : S_DONE;
            S_MOVE:   nxt = S_DONE;
            S_LOAD_A: nxt = S_LOAD_G;
            S_LOAD_G: nxt = S_EXEC;
            S_EXEC:   nxt = S_WRITE;
            S_WRITE:  nxt = S_DONE;
            default:  nxt = S_IDLE;
        endcase
    end

    // Outputs decode from the registered state and IR only, so they settle right after posedge.
    always_comb begin
        rx_oh     = onehot(ir[RX_MSB:RX_LSB]);
        ry_oh     = onehot(ir[RY_MSB:RY_LSB]);
        is_ld     = ir[OP_MSB:OP_LSB] == OP_LD;
        unused_ir = ^ir[1:0];
        Ready     = state == S_IDLE;
        Done      = state == S_DONE;
        Illegal   = Done && cls_ir == C_ILLEGAL;
        Ain       = state == S_LOAD_A;
        Gin       = state == S_LOAD_G;
        Gout      = state == S_EXEC || state == S_WRITE;
        FN        = Gout ? ir[OP_MSB:OP_LSB] : '0;
        ENW       = state == S_MOVE && is_ld;
        Rout      = state == S_LOAD_A                                  ? rx_oh :
                    (state == S_LOAD_G || (state == S_MOVE && !is_ld)) ? ry_oh : '0;
        Rin       = (state == S_MOVE || state == S_WRITE) ? rx_oh : '0;
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed checks of alu_sequencer against a small negedge datapath model.
module tb_alu_sequencer;

    logic       CLKb = 0, Clr = 1, Exec = 0;
    logic [9:0] INST = '0;
    logic       Ready, Done, Illegal, Ain, Gin, Gout, ENW;
    logic [3:0] FN, Rout, Rin;

    int n_checks = 0, n_fail = 0, viol = 0;

    logic [9:0] r [4];
    logic [9:0] a, g, q = '0, ext = '0, bus;
    logic [18:0] obs;
    localparam logic [18:0] IDLE_V = 19'h40000;

    alu_sequencer dut (
        .CLKb(CLKb), .Clr(Clr), .Exec(Exec), .INST(INST),
        .Ready(Ready), .Done(Done), .Illegal(Illegal),
        .Ain(Ain), .Gin(Gin), .Gout(Gout), .FN(FN),
        .Rout(Rout), .Rin(Rin), .ENW(ENW)
    );

    always #5 CLKb = ~CLKb;

    assign obs = {Ready, Done, Illegal, Ain, Gin, Gout, ENW, FN, Rout, Rin};

    always_comb
        bus = Rout[0] ? r[0] : Rout[1] ? r[1] : Rout[2] ? r[2] : Rout[3] ? r[3] : ENW ? ext : q;

    // Datapath model: ALU latches and register file sample on the falling edge.
    always @(negedge CLKb) begin
        if (Ain) a <= bus;
        if (Gin) g <= bus;
        if (Gout)
            case (FN)
                4'h2: q <= a + g;
                4'h3: q <= a - g;
                4'h5: q <= ~g;
                default: q <= q;
            endcase
        for (int i = 0; i < 4; i++)
            if (Rin[i]) r[i] <= bus;
        if ($countones(Rout) + int'(ENW) + int'(Gout && |Rin) > 1) viol++;
        if ($countones(Rin) > 1 || (|Rin && (Ain || Gin))) viol++;
    end

    function automatic logic [18:0] ev(input logic rd, dn, il, ai, gi, go, en,
                                       input logic [3:0] fn, ro, ri);
        return {rd, dn, il, ai, gi, go, en, fn, ro, ri};
    endfunction

    task automatic step;
        @(posedge CLKb);
        #1;
    endtask

    task automatic issue(input logic [9:0] inst, input logic [9:0] data, output int lat);
        int n = 0;
        while (!Ready && n < 20) begin step(); n++; end
        INST = inst; ext = data; Exec = 1;
        step();
        Exec = 0;
        lat = 1;
        while (!Done && lat < 20) begin step(); lat++; end
        if (!Done) lat = -1;
    endtask

    task automatic load(input logic [1:0] rx, input logic [9:0] data);
        int lat;
        issue({4'h0, rx, 4'b0000}, data, lat);
        step();
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL load_latency: got %0d want 2", lat); end
    endtask

    task automatic test_reset;
        Clr = 1; Exec = 1; INST = 10'h010;
        step();
        n_checks++;
        if (obs !== IDLE_V) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", obs, IDLE_V); end
        step();
        n_checks++;
        if (obs !== IDLE_V) begin n_fail++; $display("FAIL clr_beats_exec: got %h want %h", obs, IDLE_V); end
        Clr = 0; Exec = 0;
        step();
    endtask

    task automatic test_ld;
        INST = 10'h010; ext = 10'h155; Exec = 1;
        step();
        Exec = 0;
        n_checks++;
        if (obs !== ev(0,0,0,0,0,0,1,4'h0,4'b0000,4'b0010)) begin
            n_fail++; $display("FAIL ld_move: got %h want %h", obs, ev(0,0,0,0,0,0,1,4'h0,4'b0000,4'b0010));
        end
        step();
        n_checks++;
        if (obs !== ev(0,1,0,0,0,0,0,4'h0,4'b0000,4'b0000)) begin
            n_fail++; $display("FAIL ld_done: got %h want %h", obs, ev(0,1,0,0,0,0,0,4'h0,4'b0000,4'b0000));
        end
        step();
        n_checks++;
        if (r[1] !== 10'h155) begin n_fail++; $display("FAIL ld_result: got %h want 155", r[1]); end
    endtask

    task automatic test_add;
        logic [18:0] exp_v [1:5];
        exp_v[1] = ev(0,0,0,1,0,0,0,4'h0,4'b0010,4'b0000);
        exp_v[2] = ev(0,0,0,0,1,0,0,4'h0,4'b0100,4'b0000);
        exp_v[3] = ev(0,0,0,0,0,1,0,4'h2,4'b0000,4'b0000);
        exp_v[4] = ev(0,0,0,0,0,1,0,4'h2,4'b0000,4'b0010);
        exp_v[5] = ev(0,1,0,0,0,0,0,4'h0,4'b0000,4'b0000);
        load(2'd1, 10'd5);
        load(2'd2, 10'd3);
        INST = 10'h098; Exec = 1;
        for (int i = 1; i <= 5; i++) begin
            step();
            Exec = 0;
            if (i == 2) INST = 10'h3FF;
            n_checks++;
            if (obs !== exp_v[i]) begin n_fail++; $display("FAIL add_cycle%0d: got %h want %h", i, obs, exp_v[i]); end
        end
        step();
        n_checks++;
        if (obs !== IDLE_V || r[1] !== 10'd8) begin
            n_fail++; $display("FAIL add_result: got r1=%h obs=%h want r1=008 obs=%h", r[1], obs, IDLE_V);
        end
    endtask

    task automatic test_unary;
        int lat = 0;
        logic ain_seen = 0;
        load(2'd2, 10'h0F0);
        INST = 10'h148; Exec = 1;
        step();
        Exec = 0;
        lat = 1;
        while (!Done && lat < 20) begin ain_seen |= Ain; step(); lat++; end
        n_checks++;
        if (lat !== 4 || ain_seen !== 1'b0) begin
            n_fail++; $display("FAIL flp_timing: got lat=%0d ain=%b want lat=4 ain=0", lat, ain_seen);
        end
        step();
        n_checks++;
        if (r[0] !== 10'h30F) begin n_fail++; $display("FAIL flp_result: got %h want 30f", r[0]); end
    endtask

    task automatic test_illegal;
        INST = 10'h398; Exec = 1;
        step();
        Exec = 0;
        n_checks++;
        if (obs !== ev(0,1,1,0,0,0,0,4'h0,4'b0000,4'b0000)) begin
            n_fail++; $display("FAIL illegal_done: got %h want %h", obs, ev(0,1,1,0,0,0,0,4'h0,4'b0000,4'b0000));
        end
        step();
        n_checks++;
        if (obs !== IDLE_V) begin n_fail++; $display("FAIL illegal_idle: got %h want %h", obs, IDLE_V); end
    endtask

    task automatic test_reset_midop;
        INST = 10'h098; Exec = 1;
        step();
        Exec = 0;
        step();
        step();
        n_checks++;
        if (Gout !== 1'b1 || FN !== 4'h2) begin n_fail++; $display("FAIL midop_exec: got gout=%b fn=%h want 1 2", Gout, FN); end
        Clr = 1;
        step();
        Clr = 0;
        n_checks++;
        if (obs !== IDLE_V) begin n_fail++; $display("FAIL midop_reset: got %h want %h", obs, IDLE_V); end
        step();
        step();
        n_checks++;
        if (obs !== IDLE_V || r[1] !== 10'd8) begin
            n_fail++; $display("FAIL midop_dest: got r1=%h obs=%h want r1=008 obs=%h", r[1], obs, IDLE_V);
        end
    endtask

    task automatic test_back_to_back;
        logic [18:0] exp_v [1:5];
        exp_v[1] = ev(0,0,0,0,0,0,1,4'h0,4'b0000,4'b1000);
        exp_v[2] = ev(0,1,0,0,0,0,0,4'h0,4'b0000,4'b0000);
        exp_v[3] = ev(1,0,0,0,0,0,0,4'h0,4'b0000,4'b0000);
        exp_v[4] = ev(0,0,0,0,0,0,0,4'h0,4'b1000,4'b0001);
        exp_v[5] = ev(0,1,0,0,0,0,0,4'h0,4'b0000,4'b0000);
        INST = 10'h030; ext = 10'h2AA; Exec = 1;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 1) INST = 10'h04C;
            if (i == 5) Exec = 0;
            n_checks++;
            if (obs !== exp_v[i]) begin n_fail++; $display("FAIL b2b_cycle%0d: got %h want %h", i, obs, exp_v[i]); end
        end
        step();
        n_checks++;
        if (obs !== IDLE_V || r[0] !== 10'h2AA || r[3] !== 10'h2AA) begin
            n_fail++; $display("FAIL b2b_result: got r0=%h r3=%h obs=%h want 2aa 2aa %h", r[0], r[3], obs, IDLE_V);
        end
    endtask

    task automatic test_bus_rules;
        n_checks++;
        if (viol !== 0) begin n_fail++; $display("FAIL bus_rules: got %0d violations want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_ld();
        test_add();
        test_unary();
        test_illegal();
        test_reset_midop();
        test_back_to_back();
        test_bus_rules();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control FSM that sequences the 10-bit ALU and the 4-entry register file over the shared 10-bit data bus. It accepts one instruction word per Exec handshake and decodes it. It then drives the register-file bus enables, ALU latch strobes (Ain, Gin, Gout) and function code FN step by step until the result is written back. It sits between the instruction source (switch/ROM front end) and the datapath.

## Interface
- No parameters. Widths are fixed: data/instruction 10 bits, 4 registers, FN 4 bits.
- CLKb  in  1  datapath clock. The sequencer updates on posedge. The ALU samples on negedge, so every control output is stable half a cycle before the ALU uses it.
- Clr  in  1  reset, synchronous, active-high.
- Exec  in  1  start request, sampled on posedge.
- INST  in  10  instruction: [9:6] opcode, [5:4] Rx (dest/first operand), [3:2] Ry (second operand), [1:0] ignored.
- Ready  out  1  high in IDLE only.
- Done  out  1  one-cycle pulse when the instruction completes.
- Illegal  out  1  high together with Done when the opcode is undefined.
- Ain, Gin, Gout  out  1 each  ALU strobes.
- FN  out  4  ALU function code.
- Rout  out  4  one-hot: selected register drives the bus.
- Rin  out  4  one-hot: selected register loads from the bus.
- ENW  out  1  external data (INST-side input) drives the bus.

## Operation
- Opcodes (blueberry_pkg):
  - 0000 ld: Rx <- external data.
  - 0001 cp: Rx <- Ry.
  - 0010 add, 0011 sub, 0110 and, 0111 or, 1000 xor, 1001 lsl, 1010 lsr, 1011 asr: Rx <- Rx op Ry.
  - 0100 inv, 0101 flp: Rx <- op Ry (unary; A is not loaded).
  - 1100–1111: illegal.
- Accept rule: on a posedge with Exec=1, Ready=1 and Clr=0, INST is latched into IR and the FSM leaves IDLE. Exec in any other state is ignored; nothing is queued.
- States and the outputs asserted in each (all unlisted outputs are 0):
  - IDLE: Ready.
  - MOVE: ld asserts ENW and Rin[Rx]. cp asserts Rout[Ry] and Rin[Rx].
  - LOAD_A: Rout[Rx], Ain.
  - LOAD_G: Rout[Ry], Gin.
  - EXEC: Gout, FN=IR[9:6].
  - WRITE: Gout, FN=IR[9:6], Rin[Rx]. ALU Q drives the bus.
  - DONE: Done. Illegal is also asserted if IR is illegal.
- Transitions:
  - IDLE to MOVE for ld/cp.
  - IDLE to LOAD_A for binary ops.
  - IDLE to LOAD_G for unary ops.
  - IDLE to DONE for illegal opcodes.
  - LOAD_A to LOAD_G to EXEC to WRITE to DONE to IDLE.
  - MOVE to DONE.
- FN outside EXEC/WRITE is 0000. With that code and Gout=0, the ALU holds Q.
- Rx==Ry is legal. For cp it is a no-op write. For sub the result is 0.
- Exactly one bus driver at a time: Rout, ENW and Gout-in-WRITE are mutually exclusive. No Rin is active in the same cycle as Ain or Gin.

## Timing
- Reset: the posedge with Clr=1 forces state IDLE, IR=0 and all outputs to their IDLE values (Ready=1, all else 0). This applies from any state, mid-instruction included; a partly executed instruction is abandoned and no Rin fires afterward.
- Clr and Exec on the same edge: Clr wins and the instruction is not accepted.
- Latency from the accept edge k to the Done-high cycle:
  - binary op: DONE at edge k+5.
  - unary op: k+4.
  - ld/cp: k+2.
  - illegal: k+1.
- Ready returns one cycle after Done. Back-to-back throughput is therefore latency+1 cycles per instruction.
- INST is only sampled at accept. Later changes to INST have no effect.
- The ALU result is captured at the negedge inside EXEC and is stable for all of WRITE.

## Structure
- blueberry_pkg contains:
  - opcode_t enum (the codes above, matching the ALU FN encoding)
  - state_t enum
  - field-position localparams for INST
  - a NUM_REGS=4 constant
- One sub-module, alu_seq_decode: combinational classification of opcode into {move, unary, binary, illegal}. The FSM, IR register and output decode stay in alu_sequencer.

## Test plan
- Reset mid-op: Clr asserted during EXEC of an add -> next cycle IDLE, Ready=1, Rin=0000, Gout=0, and the destination register is unchanged.
- ld: INST=0000_01_00_00 with external data 0x155 -> MOVE with ENW=1 and Rin=0010, Done at k+2, R1=0x155.
- add: R1=5, R2=3, INST=0010_01_10_00 -> per-cycle outputs follow LOAD_A/LOAD_G/EXEC/WRITE as specified, Done at k+5, R1=8.
- unary flp: R2=0x0F0, INST=0101_00_10_00 -> Ain never asserted, Done at k+4, R0=0x30F.
- Illegal 1110_xx_xx_xx -> Done and Illegal both high at k+1, no Rin or strobe asserted at any point.
- Exec held high continuously with two different INST values -> only the first is accepted. The second is accepted on the first Ready cycle after DONE, and no Exec is accepted while Ready=0.
